acc_feeder: RTL and testbench
=============================

// Module: acc_feeder
// PURPOSE
//  Upstream stage of acc_core: buffers incoming numbers in a FIFO and, on start_i,
//  streams exactly num_cnt_i of them to acc_core as number_o/valid_o with run_o framing.
//  Then waits for acc_core's valid_o (core_done_i) and signals done_o.
//  Decouples the producer's bursty valid/ready traffic from acc_core's per-cycle input.
// PARAMETERS
//  IN_DATA_WIDTH  8   width of each number (matches acc_core IN_DATA_WIDTH)
//  FIFO_DEPTH     16  FIFO entries, power of two >= 2
//  CNT_WIDTH      8   width of the beat counter / num_cnt_i
//  TIMEOUT        255 max WAIT cycles for core_done_i before forced DONE
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  reset_n      in   1              asynchronous active-low reset
//  s_valid_i    in   1              producer data valid
//  s_data_i     in   IN_DATA_WIDTH  producer data
//  s_ready_o    out  1              FIFO can accept (= !full)
//  start_i      in   1              one-cycle pulse: begin a run (sampled in IDLE only)
//  num_cnt_i    in   CNT_WIDTH      beats to send, sampled with start_i
//  number_o     out  IN_DATA_WIDTH  data to acc_core number_i
//  valid_o      out  1              to acc_core valid_i, one cycle per beat
//  run_o        out  1              to acc_core run_i
//  core_done_i  in   1              acc_core valid_o
//  busy_o       out  1              state != IDLE
//  done_o       out  1              one-cycle pulse at run end
//  timeout_o    out  1              one-cycle pulse with done_o if WAIT timed out
// BEHAVIOUR
//  Reset: all outputs 0 except s_ready_o=1; FIFO empty, counters 0, state IDLE.
//  FIFO: push when s_valid_i && s_ready_o. s_ready_o = !full (combinational from count).
//   Pop when state==RUN && !empty && remaining!=0. Push and pop in the same cycle are
//   both honoured (count unchanged). Pointers wrap modulo FIFO_DEPTH.
//   A word pushed at edge t is poppable from edge t+1 (no fall-through).
//  number_o/valid_o/run_o are registered. A pop at edge t gives valid_o=1 and
//   number_o=popped word during cycle t+1 only. number_o holds its last value otherwise.
//  FSM IDLE/RUN/WAIT/DONE:
//   IDLE: start_i && num_cnt_i!=0 -> latch remaining=num_cnt_i, go RUN.
//    start_i && num_cnt_i==0 -> DONE, no beats sent. start_i outside IDLE is ignored.
//   RUN: run_o=1 from the cycle after entry. Each pop decrements remaining.
//    FIFO empty -> stall: run_o stays 1, valid_o=0.
//    The pop that makes remaining 0 -> WAIT. run_o and valid_o both drop after that beat.
//    core_done_i in RUN is ignored.
//   WAIT: run_o=0, wait counter increments each cycle.
//    core_done_i=1 -> DONE. Counter reaching TIMEOUT -> DONE with timeout flag set.
//   DONE: done_o=1 (timeout_o=1 if flagged) for exactly one cycle, then IDLE.
//  Leftover FIFO words beyond num_cnt_i stay queued for the next run.
//  Asserting reset_n low mid-run aborts immediately: FIFO flushed, outputs to reset values.
//  remaining is CNT_WIDTH wide. Max run = 2^CNT_WIDTH-1 beats. No wrap because 0 is never loaded.
// TESTING
//  1) Push 5 words (1..5) then start_i, num_cnt_i=5 -> valid_o high 5 consecutive
//     cycles with number_o=1,2,3,4,5; run_o high for the same 5 cycles; core_done_i
//     pulse -> done_o one cycle later, busy_o low after.
//  2) start_i, num_cnt_i=4 with FIFO empty, feed 1 word every 3 cycles -> valid_o pulses
//     spaced 3 cycles, run_o held high throughout, exactly 4 beats.
//  3) Fill FIFO with 16 words -> s_ready_o=0, 17th word not accepted.
//     Start num_cnt_i=16 -> s_ready_o=1 the cycle after first pop; all 16 delivered in order.
//  4) start_i with num_cnt_i=0 -> done_o pulse within 2 cycles, valid_o/run_o never high.
//     start_i pulsed during RUN is ignored (beat count unchanged).
//  5) core_done_i never asserted -> done_o and timeout_o pulse TIMEOUT cycles after WAIT entry.
//  6) reset_n low for 2ns after beat 2 of 8 -> all outputs 0, s_ready_o=1,
//     FIFO empty, busy_o=0. A new run of 3 works normally.

Source files
------------

// File: rtl/acc_feeder.sv
// acc_feeder: FIFO-buffered feeder that streams a counted run of numbers into acc_core
module acc_feeder #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_WIDTH     = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid_i,
  input  logic [IN_DATA_WIDTH-1:0] s_data_i,
  output logic                     s_ready_o,
  input  logic                     start_i,
  input  logic [CNT_WIDTH-1:0]     num_cnt_i,
  output logic [IN_DATA_WIDTH-1:0] number_o,
  output logic                     valid_o,
  output logic                     run_o,
  input  logic                     core_done_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;
  state_t                   state;
  logic [IN_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic [CNT_WIDTH-1:0]     remaining;
  logic [WW-1:0]            wait_cnt;
  logic                     push, pop, empty;
  assign empty     = count == '0;
  assign s_ready_o = count != (AW+1)'(FIFO_DEPTH);
  assign push      = s_valid_i && s_ready_o;
  assign pop       = (state == S_RUN) && !empty && (remaining != '0);
  assign busy_o    = state != S_IDLE;
  // storage array, left unreset since occupancy is tracked by count
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s_data_i;
  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // run sequencing with registered beat, framing and completion outputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      wait_cnt  <= '0;
      number_o  <= '0;
      valid_o   <= 1'b0;
      run_o     <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o <= pop;
      run_o   <= state == S_RUN;
      if (pop) number_o <= mem[rd_ptr];
      case (state)
        S_IDLE: if (start_i) begin
          remaining <= num_cnt_i;
          wait_cnt  <= '0;
          state     <= num_cnt_i != '0 ? S_RUN : S_DONE;
          done_o    <= num_cnt_i == '0;
        end
        S_RUN: if (pop) begin
          remaining <= remaining - 1'b1;
          if (remaining == CNT_WIDTH'(1)) state <= S_WAIT;
        end
        S_WAIT: if (core_done_i || wait_cnt == WW'(TIMEOUT - 1)) begin
          state     <= S_DONE;
          done_o    <= 1'b1;
          timeout_o <= !core_done_i;
        end else wait_cnt <= wait_cnt + 1'b1;
        default: begin
          state     <= S_IDLE;
          done_o    <= 1'b0;
          timeout_o <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_acc_feeder.sv
// tb_acc_feeder: directed self-checking bench for acc_feeder
module tb_acc_feeder;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid_i = 1'b0;
  logic [7:0] s_data_i = '0;
  logic       s_ready_o;
  logic       start_i = 1'b0;
  logic [7:0] num_cnt_i = '0;
  logic [7:0] number_o;
  logic       valid_o, run_o;
  logic       core_done_i = 1'b0;
  logic       busy_o, done_o, timeout_o;
  logic       mon_clr = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         run_cnt = 0, run_first = 0, run_last = 0;
  int         done_cnt = 0, done_cyc = 0, to_cnt = 0;
  logic [7:0] got[$];
  int         vcyc[$];

  acc_feeder dut (
    .clk(clk), .reset_n(reset_n), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_o), .start_i(start_i), .num_cnt_i(num_cnt_i),
    .number_o(number_o), .valid_o(valid_o), .run_o(run_o), .core_done_i(core_done_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // records beats, framing and completion pulses as seen during the preceding cycle
  always @(posedge clk) begin
    if (mon_clr) begin
      got.delete();
      vcyc.delete();
      run_cnt  <= 0;
      done_cnt <= 0;
      to_cnt   <= 0;
    end else begin
      if (valid_o) begin
        got.push_back(number_o);
        vcyc.push_back(cyc);
      end
      if (run_o) begin
        run_cnt <= run_cnt + 1;
        if (run_cnt == 0) run_first <= cyc;
        run_last <= cyc;
      end
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (timeout_o) to_cnt <= to_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    s_valid_i = 1'b1;
    s_data_i  = d;
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic start(input logic [7:0] n);
    start_i   = 1'b1;
    num_cnt_i = n;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (got.size() >= n && !run_o) break;
    end
    check({tag, "_bound"}, i < 300, 1);
  endtask

  task automatic check_seq(input string tag, input int base, input int n);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check({tag, "_data"}, got[i], base + i);
  endtask

  task automatic finish_core(input string tag);
    core_done_i = 1'b1;
    @(negedge clk);
    core_done_i = 1'b0;
    check({tag, "_done"}, done_o, 1);
    check({tag, "_timeout"}, timeout_o, 0);
    @(negedge clk);
    check({tag, "_done_low"}, done_o, 0);
    check({tag, "_busy_low"}, busy_o, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, s_ready_o, 1);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_run"}, run_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_tmo"}, timeout_o, 0);
  endtask

  initial begin
    int i;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("reset");
    // 1) buffered words stream back-to-back
    clr();
    for (int k = 1; k <= 5; k++) push(8'(k));
    start(5);
    wait_beats(5, "t1");
    check_seq("t1", 1, 5);
    if (vcyc.size() == 5) check("t1_consecutive", vcyc[4] - vcyc[0], 4);
    check("t1_run_cycles", run_cnt, 5);
    if (vcyc.size() == 5) check("t1_run_first", run_first, vcyc[0]);
    check("t1_busy_wait", busy_o, 1);
    finish_core("t1");
    // 2) starved FIFO: one word every 3 cycles
    clr();
    start(4);
    for (int k = 0; k < 4; k++) begin
      push(8'(10 + k));
      repeat (2) @(negedge clk);
    end
    wait_beats(4, "t2");
    check_seq("t2", 10, 4);
    for (int k = 0; k < 3 && k + 1 < vcyc.size(); k++) check("t2_spacing", vcyc[k+1] - vcyc[k], 3);
    check("t2_run_contig", run_cnt, run_last - run_first + 1);
    if (vcyc.size() == 4) check("t2_run_last", run_last, vcyc[3]);
    finish_core("t2");
    // 3) full FIFO back-pressure and drain in order
    clr();
    for (int k = 0; k < 16; k++) push(8'(20 + k));
    check("t3_full", s_ready_o, 0);
    push(8'd99);
    check("t3_still_full", s_ready_o, 0);
    start(16);
    check("t3_ready_before_pop", s_ready_o, 0);
    @(negedge clk);
    check("t3_ready_after_pop", s_ready_o, 1);
    wait_beats(16, "t3");
    check_seq("t3", 20, 16);
    finish_core("t3");
    // 4) zero-length run, then start ignored mid-run
    clr();
    start(0);
    check("t4_zero_done", done_o, 1);
    @(negedge clk);
    check("t4_zero_done_low", done_o, 0);
    check("t4_zero_busy", busy_o, 0);
    repeat (2) @(negedge clk);
    check("t4_zero_run", run_cnt, 0);
    check("t4_zero_beats", got.size(), 0);
    for (int k = 0; k < 5; k++) push(8'(40 + k));
    clr();
    start(3);
    start(5);
    wait_beats(3, "t4");
    repeat (3) @(negedge clk);
    check_seq("t4", 40, 3);
    finish_core("t4");
    // 5) no core_done: forced completion after TIMEOUT wait cycles, leftovers used
    clr();
    start(2);
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    check("t5_bound", i < 400, 1);
    @(negedge clk);
    check_seq("t5", 43, 2);
    if (vcyc.size() == 2) check("t5_latency", done_cyc - vcyc[1], 255);
    check("t5_done_pulses", done_cnt, 1);
    check("t5_timeout_pulses", to_cnt, 1);
    check("t5_busy", busy_o, 0);
    // 6) asynchronous reset mid-run flushes everything
    clr();
    for (int k = 0; k < 8; k++) push(8'(50 + k));
    start(8);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (got.size() >= 2) break;
    end
    check("t6_bound", i < 50, 1);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
    check_idle("t6_reset");
    @(negedge clk);
    clr();
    for (int k = 0; k < 3; k++) push(8'(60 + k));
    start(3);
    wait_beats(3, "t6");
    check_seq("t6", 60, 3);
    finish_core("t6");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
